// File: rtl/cond_exec_ctrl_if.sv
// rtl/cond_exec_ctrl_if.sv - EXE-stage condition/flag bus between pipeline and cond_exec_ctrl
// With COND_PERF_CNT_EN defined the exec_cnt/skip_cnt counters are carried here too.
interface cond_exec_ctrl_if;
    logic        stall;
    logic        ex_valid;
    logic [3:0]  ex_cond;
    logic        ex_s;
    logic        ex_is_branch;
    logic [3:0]  alu_status;
    logic        sr_wr_en;
    logic [3:0]  sr_wr_data;
    logic [3:0]  status;
    logic        ex_exec;
    logic        branch_taken;
    logic        flush;
`ifdef COND_PERF_CNT_EN
    logic [15:0] exec_cnt;
    logic [15:0] skip_cnt;

    modport master (
        output stall, ex_valid, ex_cond, ex_s, ex_is_branch, alu_status, sr_wr_en, sr_wr_data,
        input  status, ex_exec, branch_taken, flush, exec_cnt, skip_cnt
    );
    modport slave (
        input  stall, ex_valid, ex_cond, ex_s, ex_is_branch, alu_status, sr_wr_en, sr_wr_data,
        output status, ex_exec, branch_taken, flush, exec_cnt, skip_cnt
    );
`else
    modport master (
        output stall, ex_valid, ex_cond, ex_s, ex_is_branch, alu_status, sr_wr_en, sr_wr_data,
        input  status, ex_exec, branch_taken, flush
    );
    modport slave (
        input  stall, ex_valid, ex_cond, ex_s, ex_is_branch, alu_status, sr_wr_en, sr_wr_data,
        output status, ex_exec, branch_taken, flush
    );
`endif
endinterface

// File: rtl/cond_exec_ctrl.sv
// rtl/cond_exec_ctrl.sv - NZCV owner, condition evaluation and post-branch flush sequencer
// Optional COND_PERF_CNT_EN adds 16-bit executed/skipped instruction counters.
module cond_exec_ctrl #(
    parameter int FLUSH_DEPTH = 2
) (
    input logic            clk,
    input logic            rst,
    cond_exec_ctrl_if.slave bus
);
    typedef enum logic {IDLE, FLUSH} state_e;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_DEPTH - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] status_q, status_d;
    logic       pass;
    logic       exec;
    logic       taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            status_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        logic n, z, c, v;
        n = status_q[3];
        z = status_q[2];
        c = status_q[1];
        v = status_q[0];
        pass = 1'b0;
        case (bus.ex_cond)
            4'b0000: pass = z;
            4'b0001: pass = ~z;
            4'b0010: pass = c;
            4'b0011: pass = ~c;
            4'b0100: pass = n;
            4'b0101: pass = ~n;
            4'b0110: pass = v;
            4'b0111: pass = ~v;
            4'b1000: pass = c & ~z;
            4'b1001: pass = ~c | z;
            4'b1010: pass = (n == v);
            4'b1011: pass = (n != v);
            4'b1100: pass = ~z & (n == v);
            4'b1101: pass = z | (n != v);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        status_d = status_q;
        // Instructions in EXE during FLUSH are wrong-path and must never execute.
        exec     = bus.ex_valid & pass & (state_q == IDLE);
        taken    = exec & bus.ex_is_branch & ~bus.stall;

        if (!bus.stall) begin
            if (bus.sr_wr_en) begin
                status_d = bus.sr_wr_data;
            end else if (exec && bus.ex_s) begin
                status_d = bus.alu_status;
            end
        end

        case (state_q)
            IDLE: begin
                if (taken) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (!bus.stall) begin
                    if (cnt_q == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.status       = status_q;
    assign bus.ex_exec      = exec;
    assign bus.branch_taken = taken;
    assign bus.flush        = (state_q == FLUSH);

`ifdef COND_PERF_CNT_EN
    logic [15:0] exec_cnt_q, exec_cnt_d;
    logic [15:0] skip_cnt_q, skip_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exec_cnt_q <= 16'd0;
            skip_cnt_q <= 16'd0;
        end else begin
            exec_cnt_q <= exec_cnt_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    always_comb begin
        exec_cnt_d = exec_cnt_q;
        skip_cnt_d = skip_cnt_q;
        if (!bus.stall) begin
            if (exec) begin
                exec_cnt_d = exec_cnt_q + 16'd1;
            end else if (bus.ex_valid) begin
                skip_cnt_d = skip_cnt_q + 16'd1;
            end
        end
    end

    assign bus.exec_cnt = exec_cnt_q;
    assign bus.skip_cnt = skip_cnt_q;
`endif
endmodule

// File: tb/tb_cond_exec_ctrl.sv
// tb/tb_cond_exec_ctrl.sv - directed vector bench for cond_exec_ctrl
// Perf-counter checks are built only when COND_PERF_CNT_EN is defined.
module tb_cond_exec_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    cond_exec_ctrl_if bus ();

    cond_exec_ctrl #(.FLUSH_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       stall;
        logic       valid;
        logic [3:0] cond;
        logic       s;
        logic       br;
        logic [3:0] alu;
        logic       wr_en;
        logic [3:0] wr_data;
        logic       e_exec;
        logic       e_br;
        logic [3:0] e_status;
        logic       e_flush;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic stall, input logic valid, input logic [3:0] cond,
                       input logic s, input logic br, input logic [3:0] alu,
                       input logic wr_en, input logic [3:0] wr_data,
                       input logic e_exec, input logic e_br, input logic [3:0] e_status,
                       input logic e_flush);
        vec_t v;
        v.stall = stall; v.valid = valid; v.cond = cond; v.s = s; v.br = br;
        v.alu = alu; v.wr_en = wr_en; v.wr_data = wr_data;
        v.e_exec = e_exec; v.e_br = e_br; v.e_status = e_status; v.e_flush = e_flush;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic stall, input logic valid, input logic [3:0] cond,
                         input logic s, input logic br);
        bus.stall = stall; bus.ex_valid = valid; bus.ex_cond = cond;
        bus.ex_s = s; bus.ex_is_branch = br;
        bus.alu_status = 4'h0; bus.sr_wr_en = 1'b0; bus.sr_wr_data = 4'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int flush_cycles;

    initial begin
        drive(1'b0, 1'b1, 4'hE, 1'b0, 1'b0);
        #1;
        chk("reset_status", bus.status, 4'h0);
        chk("reset_flush", bus.flush, 0);
        chk("reset_exec", bus.ex_exec, 1);
        chk("reset_branch", bus.branch_taken, 0);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();

        // stall valid cond s br alu wr wd | exec br status flush
        add(0,1,4'hE,0,0,4'h0,0,4'h0, 1,0,4'h0,0);
        add(0,1,4'hF,0,0,4'h0,0,4'h0, 0,0,4'h0,0);
        add(0,1,4'h0,0,0,4'h0,0,4'h0, 0,0,4'h0,0);
        add(0,1,4'hE,1,0,4'h4,0,4'h0, 1,0,4'h0,0);
        add(0,1,4'h0,0,0,4'h0,0,4'h0, 1,0,4'h4,0);
        add(0,1,4'h1,0,0,4'h0,0,4'h0, 0,0,4'h4,0);
        add(0,1,4'hE,1,0,4'h6,1,4'h9, 1,0,4'h4,0);
        add(0,1,4'h4,0,0,4'h0,0,4'h0, 1,0,4'h9,0);
        add(0,1,4'h6,0,0,4'h0,0,4'h0, 1,0,4'h9,0);
        add(0,1,4'hA,0,0,4'h0,0,4'h0, 1,0,4'h9,0);
        add(0,1,4'hB,0,0,4'h0,0,4'h0, 0,0,4'h9,0);
        add(0,1,4'h8,0,0,4'h0,0,4'h0, 0,0,4'h9,0);
        add(0,1,4'h9,0,0,4'h0,0,4'h0, 1,0,4'h9,0);
        add(0,1,4'hC,0,0,4'h0,0,4'h0, 1,0,4'h9,0);
        add(0,1,4'hD,0,0,4'h0,0,4'h0, 0,0,4'h9,0);
        add(0,1,4'h2,0,0,4'h0,0,4'h0, 0,0,4'h9,0);
        add(0,1,4'h3,0,0,4'h0,0,4'h0, 1,0,4'h9,0);
        add(0,1,4'h5,0,0,4'h0,0,4'h0, 0,0,4'h9,0);
        add(0,1,4'h7,0,0,4'h0,0,4'h0, 0,0,4'h9,0);
        add(0,0,4'hE,1,1,4'h0,0,4'h0, 0,0,4'h9,0);
        add(1,1,4'hE,1,1,4'h0,0,4'h0, 1,0,4'h9,0);
        add(0,1,4'hE,0,1,4'h0,0,4'h0, 1,1,4'h9,0);
        add(0,1,4'hE,1,1,4'h0,0,4'h0, 0,0,4'h9,1);
        add(0,1,4'hE,1,1,4'h0,0,4'h0, 0,0,4'h9,1);
        add(0,1,4'hE,0,0,4'h0,0,4'h0, 1,0,4'h9,0);

        foreach (vecs[i]) begin
            bus.stall = vecs[i].stall; bus.ex_valid = vecs[i].valid;
            bus.ex_cond = vecs[i].cond; bus.ex_s = vecs[i].s;
            bus.ex_is_branch = vecs[i].br; bus.alu_status = vecs[i].alu;
            bus.sr_wr_en = vecs[i].wr_en; bus.sr_wr_data = vecs[i].wr_data;
            #3;
            chk($sformatf("v%0d_exec", i), bus.ex_exec, vecs[i].e_exec);
            chk($sformatf("v%0d_branch", i), bus.branch_taken, vecs[i].e_br);
            chk($sformatf("v%0d_status", i), bus.status, vecs[i].e_status);
            chk($sformatf("v%0d_flush", i), bus.flush, vecs[i].e_flush);
            next_cycle();
        end

        // Flush window stretched by three stall cycles.
        drive(1'b0, 1'b1, 4'hE, 1'b0, 1'b1);
        #3;
        chk("stall_win_branch", bus.branch_taken, 1);
        next_cycle();
        flush_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            drive((i >= 1 && i <= 3), 1'b0, 4'hE, 1'b0, 1'b0);
            #3;
            if (bus.flush) flush_cycles++;
            next_cycle();
        end
        chk("stall_win_len", flush_cycles, 5);

        // Asynchronous reset in the middle of a flush window.
        drive(1'b0, 1'b1, 4'hE, 1'b0, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 4'hE, 1'b0, 1'b0);
        #1;
        chk("pre_rst_flush", bus.flush, 1);
        chk("pre_rst_status", bus.status, 4'h9);
        rst = 1'b1;
        #1;
        chk("async_rst_flush", bus.flush, 0);
        chk("async_rst_status", bus.status, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        chk("post_rst_flush", bus.flush, 0);

`ifdef COND_PERF_CNT_EN
        chk("perf_reset_exec", bus.exec_cnt, 0);
        chk("perf_reset_skip", bus.skip_cnt, 0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, (i < 5) ? 4'hE : 4'hF, 1'b0, 1'b0);
            next_cycle();
        end
        drive(1'b0, 1'b0, 4'hE, 1'b0, 1'b0);
        #1;
        chk("perf_exec_cnt", bus.exec_cnt, 5);
        chk("perf_skip_cnt", bus.skip_cnt, 3);
        drive(1'b1, 1'b1, 4'hE, 1'b0, 1'b0);
        next_cycle();
        chk("perf_stall_hold", bus.exec_cnt, 5);
        for (int i = 0; i < 65530; i++) begin
            drive(1'b0, 1'b1, 4'hE, 1'b0, 1'b0);
            next_cycle();
        end
        chk("perf_exec_max", bus.exec_cnt, 16'hFFFF);
        next_cycle();
        chk("perf_exec_wrap", bus.exec_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
